// File: rtl/ascon_output_collector_pkg.sv
// Shared definitions for the Ascon output collector: FSM encoding, counter width
// and the byte-count derivation used to size the capture window.
package ascon_output_collector_pkg;

  localparam int CNT_W = 16;

  typedef logic [2:0] stateVec_t;

  localparam stateVec_t ST_IDLE    = 3'd0;
  localparam stateVec_t ST_RUN     = 3'd1;
  localparam stateVec_t ST_DELAY   = 3'd2;
  localparam stateVec_t ST_CAPTURE = 3'd3;
  localparam stateVec_t ST_HOLD    = 3'd4;

  // The core streams as many bytes as its widest operand, so the window follows the largest length.
  function automatic int calcNbytes(input int k, input int l, input int y);
    int widest;
    widest = k;
    if (l > widest) widest = l;
    if (y > widest) widest = y;
    return widest / 8;
  endfunction

endpackage

// File: rtl/ascon_edge_detect.sv
// Registered rising-edge detector: rise is high for the one cycle in which sig is
// high but was low at the previous clock edge.
module ascon_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sigQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sigQ <= 1'b0;
    end else begin
      sigQ <= sig;
    end
  end

  assign rise = sig & ~sigQ;

endmodule

// File: rtl/ascon_output_collector.sv
// Collects the masked Ascon core's byte-serial cipher-text and tag after each
// encryption, measures the run latency and holds the result behind valid/ack.
module ascon_output_collector
  import ascon_output_collector_pkg::*;
#(
  parameter int K          = 128,
  parameter int L          = 40,
  parameter int Y          = 40,
  parameter int READ_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              encryption_startxSI,
  input  logic              encryption_readyxSI,
  input  logic [7:0]        cipher_textxSI,
  input  logic [7:0]        tagxSI,
  input  logic              ackxSI,
  output logic [Y-1:0]      cipher_textxSO,
  output logic [127:0]      tagxSO,
  output logic              validxSO,
  output logic              busyxSO,
  output logic [CNT_W-1:0]  cyclesxSO
);

  localparam int NBYTES    = calcNbytes(K, L, Y);
  localparam int CT_BYTES  = Y / 8;
  localparam int TAG_BYTES = 16;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(NBYTES - 1);

  stateVec_t        state;
  logic [CNT_W-1:0] latCnt;
  logic [CNT_W-1:0] delayCnt;
  logic [CNT_W-1:0] byteIdx;
  logic             startRise;
  logic             readyRise;

  ascon_edge_detect startEdge (
    .clk  (clk),
    .rst  (rst),
    .sig  (encryption_startxSI),
    .rise (startRise)
  );

  ascon_edge_detect readyEdge (
    .clk  (clk),
    .rst  (rst),
    .sig  (encryption_readyxSI),
    .rise (readyRise)
  );

  // Control path: run tracking, settle delay, byte index and the valid/ack handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      latCnt    <= '0;
      delayCnt  <= '0;
      byteIdx   <= '0;
      cyclesxSO <= '0;
      validxSO  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startRise) begin
            state  <= ST_RUN;
            latCnt <= '0;
          end
        end
        ST_RUN: begin
          if (latCnt != '1) latCnt <= latCnt + 1'b1;
          if (readyRise) begin
            cyclesxSO <= latCnt;
            delayCnt  <= '0;
            byteIdx   <= '0;
            state     <= (READ_DELAY == 0) ? ST_CAPTURE : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (delayCnt == DELAY_LAST) begin
            state <= ST_CAPTURE;
          end else begin
            delayCnt <= delayCnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (byteIdx == BYTE_LAST) begin
            state    <= ST_HOLD;
            validxSO <= 1'b1;
          end else begin
            byteIdx <= byteIdx + 1'b1;
          end
        end
        ST_HOLD: begin
          if (ackxSI) begin
            state    <= ST_IDLE;
            validxSO <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data path: byte c lands at bits [8c+7:8c]; bytes beyond an output's width are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cipher_textxSO <= '0;
      tagxSO         <= '0;
    end else if (state == ST_CAPTURE) begin
      for (int i = 0; i < CT_BYTES; i++) begin
        if (byteIdx == CNT_W'(i)) cipher_textxSO[i*8 +: 8] <= cipher_textxSI;
      end
      for (int i = 0; i < TAG_BYTES; i++) begin
        if (byteIdx == CNT_W'(i)) tagxSO[i*8 +: 8] <= tagxSI;
      end
    end
  end

  assign busyxSO = (state != ST_IDLE);

endmodule
